// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Brief    : Shared scan-controller state encoding, width helper and default
//            panel geometry.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

  localparam int DEFAULT_COLUMNS         = 64;
  localparam int DEFAULT_ROW_ADDR_WIDTH  = 4;
  localparam int DEFAULT_BRIGHTNESS_BITS = 6;
  localparam int DEFAULT_LSB_ON_TICKS    = 16;
  localparam int DEFAULT_LSB_ON_WIDTH    = 5;
  localparam int DEFAULT_BLANK_TICKS     = 2;

  localparam int STATE_WIDTH = 3;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SHIFT   = 3'd1;
  localparam logic [2:0] ST_CLK_HI  = 3'd2;
  localparam logic [2:0] ST_WAIT_ON = 3'd3;
  localparam logic [2:0] ST_BLANK   = 3'd4;
  localparam logic [2:0] ST_LATCH   = 3'd5;

  // Never returns 0 so single-entry fields still get a 1-bit vector.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcm_on_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcm_on_timer
// Brief    : Weighted, dimmed on-time for the latched bit-plane and the
//            down-counter that qualifies output enable.
// Revision : 1.0 - initial release
// ============================================================================
module bcm_on_timer
  import matrix_pkg::*;
#(
  parameter int BRIGHTNESS_BITS = DEFAULT_BRIGHTNESS_BITS,
  parameter int LSB_ON_TICKS    = DEFAULT_LSB_ON_TICKS,
  parameter int LSB_ON_WIDTH    = DEFAULT_LSB_ON_WIDTH,
  parameter int PLANE_WIDTH     = clog2(BRIGHTNESS_BITS)
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   load,
  input  logic [PLANE_WIDTH-1:0] plane,
  input  logic [7:0]             dim,
  output logic                   timer_zero,
  output logic                   active_next
);

  localparam int PRODUCT_WIDTH = LSB_ON_WIDTH + BRIGHTNESS_BITS + 9;

  logic [8:0]               w_dim_plus;
  logic [PRODUCT_WIDTH-1:0] w_base;
  logic [PRODUCT_WIDTH-1:0] w_product;
  logic [PRODUCT_WIDTH-1:0] w_target;
  logic [PRODUCT_WIDTH-1:0] w_timer_next;
  logic [PRODUCT_WIDTH-1:0] r_timer;

  always_comb begin
    w_dim_plus = {1'b0, dim} + 9'd1;
    w_base     = PRODUCT_WIDTH'(LSB_ON_TICKS) << plane;
    w_product  = w_base * {{(PRODUCT_WIDTH-9){1'b0}}, w_dim_plus};
    w_target   = w_product >> 8;
    // The counter keeps running in every state, so a plane finishes its
    // on-time even after the scanner has gone idle.
    if (load) begin
      w_timer_next = w_target;
    end else if (r_timer != '0) begin
      w_timer_next = r_timer - PRODUCT_WIDTH'(1);
    end else begin
      w_timer_next = r_timer;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_timer <= '0;
    end else begin
      r_timer <= w_timer_next;
    end
  end

  assign timer_zero  = (r_timer == '0);
  assign active_next = (w_timer_next != '0);

endmodule
`default_nettype wire

// File: rtl/matrix_scan_bcm.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan_bcm
// Brief    : HUB75 scan controller: shifts one bit-plane of one row pair while
//            the previously latched plane is displayed for its BCM on-time.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_scan_bcm
  import matrix_pkg::*;
#(
  parameter int COLUMNS         = DEFAULT_COLUMNS,
  parameter int ROW_ADDR_WIDTH  = DEFAULT_ROW_ADDR_WIDTH,
  parameter int BRIGHTNESS_BITS = DEFAULT_BRIGHTNESS_BITS,
  parameter int LSB_ON_TICKS    = DEFAULT_LSB_ON_TICKS,
  parameter int LSB_ON_WIDTH    = DEFAULT_LSB_ON_WIDTH,
  parameter int BLANK_TICKS     = DEFAULT_BLANK_TICKS
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [7:0]                    dim,
  input  logic                          pixel_ack,
  output logic                          pixel_req,
  output logic [clog2(COLUMNS)-1:0]     column_address,
  output logic [ROW_ADDR_WIDTH-1:0]     row_address,
  output logic [BRIGHTNESS_BITS-1:0]    brightness_mask,
  output logic [ROW_ADDR_WIDTH-1:0]     row_address_active,
  output logic                          clk_pixel,
  output logic                          row_latch,
  output logic                          output_enable,
  output logic                          frame_start,
  output logic                          busy
);

  localparam int COL_W   = clog2(COLUMNS);
  localparam int PLANE_W = clog2(BRIGHTNESS_BITS);
  localparam int BLANK_W = clog2(BLANK_TICKS + 1);

  logic [STATE_WIDTH-1:0]    r_state;
  logic [PLANE_W-1:0]        r_plane;
  logic [BLANK_W-1:0]        r_blank_cnt;

  logic [STATE_WIDTH-1:0]    w_state_next;
  logic [COL_W-1:0]          w_column_next;
  logic [ROW_ADDR_WIDTH-1:0] w_row_next;
  logic [PLANE_W-1:0]        w_plane_next;
  logic [BLANK_W-1:0]        w_blank_next;
  logic                      w_latch;
  logic                      w_last_plane;
  logic                      w_timer_zero;
  logic                      w_timer_active_next;

  assign w_latch      = (r_state == ST_LATCH);
  assign w_last_plane = (r_plane == PLANE_W'(BRIGHTNESS_BITS - 1));

  bcm_on_timer #(
    .BRIGHTNESS_BITS (BRIGHTNESS_BITS),
    .LSB_ON_TICKS    (LSB_ON_TICKS),
    .LSB_ON_WIDTH    (LSB_ON_WIDTH),
    .PLANE_WIDTH     (PLANE_W)
  ) u_on_timer (
    .clk_in      (clk_in),
    .reset       (reset),
    .load        (w_latch),
    .plane       (r_plane),
    .dim         (dim),
    .timer_zero  (w_timer_zero),
    .active_next (w_timer_active_next)
  );

  always_comb begin
    w_state_next  = r_state;
    w_column_next = column_address;
    w_row_next    = row_address;
    w_plane_next  = r_plane;
    w_blank_next  = r_blank_cnt;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_next  = ST_SHIFT;
          w_column_next = '0;
          w_row_next    = '0;
          w_plane_next  = '0;
        end
      end
      ST_SHIFT: begin
        if (pixel_ack) w_state_next = ST_CLK_HI;
      end
      ST_CLK_HI: begin
        if (column_address != COL_W'(COLUMNS - 1)) begin
          w_column_next = column_address + COL_W'(1);
          w_state_next  = ST_SHIFT;
        end else begin
          w_column_next = '0;
          w_state_next  = ST_WAIT_ON;
        end
      end
      ST_WAIT_ON: begin
        if (w_timer_zero) begin
          w_state_next = ST_BLANK;
          w_blank_next = BLANK_W'(BLANK_TICKS - 1);
        end
      end
      ST_BLANK: begin
        if (r_blank_cnt == '0) w_state_next = ST_LATCH;
        else                   w_blank_next = r_blank_cnt - BLANK_W'(1);
      end
      ST_LATCH: begin
        w_state_next = enable ? ST_SHIFT : ST_IDLE;
        if (w_last_plane) begin
          w_plane_next = '0;
          w_row_next   = row_address + ROW_ADDR_WIDTH'(1);
        end else begin
          w_plane_next = r_plane + PLANE_W'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_state            <= ST_IDLE;
      r_plane            <= '0;
      r_blank_cnt        <= '0;
      column_address     <= '0;
      row_address        <= '0;
      brightness_mask    <= BRIGHTNESS_BITS'(1);
      row_address_active <= '0;
      pixel_req          <= 1'b0;
      clk_pixel          <= 1'b0;
      row_latch          <= 1'b0;
      output_enable      <= 1'b0;
      frame_start        <= 1'b0;
      busy               <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_plane         <= w_plane_next;
      r_blank_cnt     <= w_blank_next;
      column_address  <= w_column_next;
      row_address     <= w_row_next;
      brightness_mask <= BRIGHTNESS_BITS'(1) << w_plane_next;
      if (w_latch) row_address_active <= row_address;
      pixel_req       <= (w_state_next == ST_SHIFT);
      clk_pixel       <= (w_state_next == ST_CLK_HI);
      row_latch       <= (w_state_next == ST_LATCH);
      busy            <= (w_state_next != ST_IDLE);
      frame_start     <= w_latch && w_last_plane && (&row_address);
      output_enable   <= w_timer_active_next &&
                         (w_state_next != ST_BLANK) && (w_state_next != ST_LATCH);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_bcm.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_scan_bcm
// Brief    : Directed bench for matrix_scan_bcm on a 4-column, 2-row-pair,
//            2-plane panel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_bcm;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] dim;
  logic       pixel_ack;
  logic       pixel_req;
  logic [1:0] column_address;
  logic [0:0] row_address;
  logic [1:0] brightness_mask;
  logic [0:0] row_address_active;
  logic       clk_pixel;
  logic       row_latch;
  logic       output_enable;
  logic       frame_start;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  int m_cycles, m_pulses, m_oe, m_frames, m_first_pulse, m_last_pulse, m_timeout;
  logic [31:0] m_first_row, m_first_mask, m_first_oe, m_first_frame, m_first_row_active;

  always #5 clk = ~clk;

  matrix_scan_bcm #(
    .COLUMNS         (4),
    .ROW_ADDR_WIDTH  (1),
    .BRIGHTNESS_BITS (2),
    .LSB_ON_TICKS    (8),
    .LSB_ON_WIDTH    (5),
    .BLANK_TICKS     (2)
  ) dut (
    .clk_in             (clk),
    .reset              (reset),
    .enable             (enable),
    .dim                (dim),
    .pixel_ack          (pixel_ack),
    .pixel_req          (pixel_req),
    .column_address     (column_address),
    .row_address        (row_address),
    .brightness_mask    (brightness_mask),
    .row_address_active (row_address_active),
    .clk_pixel          (clk_pixel),
    .row_latch          (row_latch),
    .output_enable      (output_enable),
    .frame_start        (frame_start),
    .busy               (busy)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic sample();
    @(negedge clk);
    m_cycles++;
    if (clk_pixel) begin
      if (m_first_pulse < 0) m_first_pulse = m_cycles;
      m_last_pulse = m_cycles;
      m_pulses++;
    end
    if (output_enable) m_oe++;
    if (frame_start) m_frames++;
  endtask

  // Runs one row-plane period up to and including the row_latch sample.
  task automatic run_to_latch(input logic [7:0] new_dim, input int stall_col, input logic new_en);
    bit stalled;
    stalled = 1'b0;
    m_cycles = 0; m_pulses = 0; m_oe = 0; m_frames = 0;
    m_first_pulse = -1; m_last_pulse = -1; m_timeout = 0;
    sample();
    m_first_row        = 32'(row_address);
    m_first_mask       = 32'(brightness_mask);
    m_first_oe         = 32'(output_enable);
    m_first_frame      = 32'(frame_start);
    m_first_row_active = 32'(row_address_active);
    dim    = new_dim;
    enable = new_en;
    while (!row_latch) begin
      if (m_cycles >= 200) begin
        m_timeout = 1;
        break;
      end
      if (stall_col >= 0 && !stalled && pixel_req && (32'(column_address) == stall_col)) begin
        stalled   = 1'b1;
        pixel_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
          sample();
          check("stall_column", 32'(column_address), stall_col);
          check("stall_req", 32'(pixel_req), 1);
          check("stall_clk_pixel", 32'(clk_pixel), 0);
        end
        pixel_ack = 1'b1;
      end
      sample();
    end
    check("latch_timeout", m_timeout, 0);
    check("latch_oe_low", 32'(output_enable), 0);
  endtask

  initial begin
    int idle_oe, idle_busy, idle_req, idle_frames;
    reset = 1'b0; enable = 1'b1; pixel_ack = 1'b1; dim = 8'd255;
    repeat (3) @(negedge clk);
    check("rst_pixel_req", 32'(pixel_req), 0);
    check("rst_clk_pixel", 32'(clk_pixel), 0);
    check("rst_row_latch", 32'(row_latch), 0);
    check("rst_oe", 32'(output_enable), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mask", 32'(brightness_mask), 1);
    check("rst_column", 32'(column_address), 0);
    check("rst_row", 32'(row_address), 0);
    check("rst_row_active", 32'(row_address_active), 0);

    reset = 1'b1;
    // Row 0 / plane 0: first WAIT_ON passes at once, nothing displayed.
    run_to_latch(8'd255, -1, 1'b1);
    check("r1_period", m_cycles, 12);
    check("r1_pulses", m_pulses, 4);
    check("r1_pulse_span", m_last_pulse - m_first_pulse, 6);
    check("r1_blank_to_latch", m_cycles - m_last_pulse, 4);
    check("r1_oe", m_oe, 0);
    check("r1_mask", m_first_mask, 1);

    // Row 0 / plane 1 load while plane 0 shows for 8 ticks.
    run_to_latch(8'd255, -1, 1'b1);
    check("r2_period", m_cycles, 12);
    check("r2_pulses", m_pulses, 4);
    check("r2_oe", m_oe, 8);
    check("r2_oe_after_latch", m_first_oe, 1);
    check("r2_mask", m_first_mask, 2);
    check("r2_row", m_first_row, 0);

    // Row 1 / plane 0 load while plane 1 shows for 16 ticks.
    run_to_latch(8'd255, -1, 1'b1);
    check("r3_period", m_cycles, 20);
    check("r3_oe", m_oe, 16);
    check("r3_row", m_first_row, 1);
    check("r3_mask", m_first_mask, 1);

    // Row 1 / plane 1 with a 5-cycle ack stall at column 2.
    run_to_latch(8'd255, 2, 1'b1);
    check("r4_period", m_cycles, 17);
    check("r4_pulses", m_pulses, 4);
    check("r4_oe", m_oe, 8);
    check("r4_row_active", m_first_row_active, 1);
    check("r4_mask", m_first_mask, 2);

    // Frame wrap; dim=0 is sampled at this period's latch.
    run_to_latch(8'd0, -1, 1'b1);
    check("wrap_frame_first", m_first_frame, 1);
    check("wrap_frame_count", m_frames, 1);
    check("wrap_row", m_first_row, 0);
    check("wrap_mask", m_first_mask, 1);
    check("wrap_oe_first", m_first_oe, 1);
    check("r5_period", m_cycles, 20);
    check("r5_oe", m_oe, 16);

    // Plane 0 with zero target never lights; dim=127 for the plane-1 latch.
    run_to_latch(8'd127, -1, 1'b1);
    check("dim0_oe", m_oe, 0);
    check("dim0_oe_first", m_first_oe, 0);
    check("dim0_period", m_cycles, 12);

    run_to_latch(8'd255, -1, 1'b1);
    check("dim127_oe", m_oe, 8);
    check("dim127_period", m_cycles, 12);

    // Drop enable just after entering SHIFT: row completes, then idle.
    run_to_latch(8'd255, -1, 1'b0);
    check("drop_period", m_cycles, 12);
    check("drop_oe", m_oe, 8);
    idle_oe = 0; idle_busy = 0; idle_req = 0; idle_frames = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (output_enable) idle_oe++;
      if (busy) idle_busy++;
      if (pixel_req) idle_req++;
      if (frame_start) idle_frames++;
    end
    check("idle_oe_full", idle_oe, 16);
    check("idle_busy", idle_busy, 0);
    check("idle_req", idle_req, 0);
    check("idle_frame", idle_frames, 1);
    check("idle_row_active", 32'(row_address_active), 1);

    // Restart, then reset in the middle of an on-time.
    enable = 1'b1;
    run_to_latch(8'd255, -1, 1'b1);
    check("restart_row", m_first_row, 0);
    check("restart_mask", m_first_mask, 1);
    check("restart_period", m_cycles, 12);
    repeat (3) @(negedge clk);
    check("pre_reset_oe", 32'(output_enable), 1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_oe", 32'(output_enable), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_pixel_req", 32'(pixel_req), 0);
    check("midrst_mask", 32'(brightness_mask), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
